axis_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges N AXI-Stream sources onto one AXI-Stream sink. A grant is held from the first beat of a packet through its tlast beat, so packets never interleave. Output passes through a full-throughput register slice. It sits upstream of the stream alignment / width-conversion datapath so that several producers can share that datapath.

---
 rtl/axis_pkg.sv | 39 +++
 rtl/axis_rr_arbiter_if.sv | 52 +++++
 rtl/axis_reg_slice.sv | 112 +++++++++++
 rtl/axis_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared types and helpers for the AXI-Stream library.
//   arb_state_t   : arbiter FSM state (IDLE, GRANT)
//   rr_next_index : round-robin pick of the next requester after 'last'
package axis_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned RR_MAX_PORTS = 16;
    localparam int unsigned RR_IDX_W     = 4;

    // Scans last+1, last+2, ... with wrap at n_ports and returns the first
    // requester. Returns 'last' when nothing requests (caller gates on |req).
    function automatic logic [RR_IDX_W-1:0] rr_next_index(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]     last,
        input int unsigned             n_ports
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_PORTS; k++) begin
            idx = 32'(last) + k;
            if (idx >= n_ports) begin
                idx = idx - n_ports;
            end
            if ((k <= n_ports) && !found && req[idx[RR_IDX_W-1:0]]) begin
                pick  = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: stream bundle for the round-robin arbiter.
//   s_axis_* : N_PORTS packed source streams (port i at [i*W +: W])
//   m_axis_* : merged sink stream
//   m_axis_tid exists only when AXIS_RR_ARB_TID_EN is defined.
// Modports:
//   slave  : arbiter view (consumes sources, drives the sink)
//   master : environment view (drives sources, consumes the sink)
interface axis_rr_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int AXIS_DW = 64,
    parameter int AXIS_KW = ((AXIS_DW-1)>>3)+1
);
`ifdef AXIS_RR_ARB_TID_EN
    localparam int PORT_W = $clog2(N_PORTS);
`endif

    logic [N_PORTS-1:0]         s_axis_tvalid;
    logic [N_PORTS-1:0]         s_axis_tready;
    logic [N_PORTS*AXIS_DW-1:0] s_axis_tdata;
    logic [N_PORTS*AXIS_KW-1:0] s_axis_tkeep;
    logic [N_PORTS-1:0]         s_axis_tlast;

    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [AXIS_DW-1:0]         m_axis_tdata;
    logic [AXIS_KW-1:0]         m_axis_tkeep;
    logic                       m_axis_tlast;
`ifdef AXIS_RR_ARB_TID_EN
    logic [PORT_W-1:0]          m_axis_tid;
`endif

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
`ifdef AXIS_RR_ARB_TID_EN
        output m_axis_tid,
`endif
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
`ifdef AXIS_RR_ARB_TID_EN
        input  m_axis_tid,
`endif
        output m_axis_tready
    );

endinterface

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: full-throughput AXI-Stream register slice (main + skid).
// The sink is driven only from the main register; input ready is "skid empty",
// so ready is a pure register output and never depends on m_ready_i.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   s_valid_i/s_ready_o    : input handshake; s_data_i/s_keep_i/s_last_i/s_user_i payload
//   m_valid_o/m_ready_i    : output handshake; m_data_o/m_keep_o/m_last_o/m_user_o payload
// USER_EN = 0 removes the user sideband storage; m_user_o then reads zero.
module axis_reg_slice #(
    parameter int DW      = 64,
    parameter int KW      = ((DW-1)>>3)+1,
    parameter int USER_W  = 1,
    parameter bit USER_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DW-1:0]     s_data_i,
    input  logic [KW-1:0]     s_keep_i,
    input  logic              s_last_i,
    input  logic [USER_W-1:0] s_user_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DW-1:0]     m_data_o,
    output logic [KW-1:0]     m_keep_o,
    output logic              m_last_o,
    output logic [USER_W-1:0] m_user_o
);
    localparam int PW = DW + KW + 1;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_pl_q, main_pl_d, skid_pl_q, skid_pl_d;
    logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic          accept, main_open;
    logic          load_main_skid, load_main_in, load_skid_in;

    assign in_pl     = {s_data_i, s_keep_i, s_last_i};
    assign s_ready_o = ~skid_valid_q;
    assign accept    = s_valid_i & ~skid_valid_q;
    // Main can take a new beat when it is empty or being drained this cycle.
    assign main_open = m_ready_i | ~main_valid_q;

    assign load_main_skid = main_open & skid_valid_q;
    assign load_main_in   = main_open & ~skid_valid_q & accept;
    assign load_skid_in   = ~main_open & accept;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pl_d    = main_pl_q;
        skid_valid_d = skid_valid_q;
        skid_pl_d    = skid_pl_q;
        if (main_open) begin
            main_valid_d = skid_valid_q | accept;
        end
        if (load_main_skid) begin
            main_pl_d = skid_pl_q;
        end else if (load_main_in) begin
            main_pl_d = in_pl;
        end
        if (load_main_skid) begin
            skid_valid_d = 1'b0;
        end else if (load_skid_in) begin
            skid_valid_d = 1'b1;
            skid_pl_d    = in_pl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_pl_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pl_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pl_q    <= main_pl_d;
            skid_valid_q <= skid_valid_d;
            skid_pl_q    <= skid_pl_d;
        end
    end

    assign m_valid_o                      = main_valid_q;
    assign {m_data_o, m_keep_o, m_last_o} = main_pl_q;

    generate
        if (USER_EN) begin : g_user
            logic [USER_W-1:0] main_user_q, skid_user_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_user_q <= '0;
                    skid_user_q <= '0;
                end else begin
                    if (load_main_skid) begin
                        main_user_q <= skid_user_q;
                    end else if (load_main_in) begin
                        main_user_q <= s_user_i;
                    end
                    if (load_skid_in) begin
                        skid_user_q <= s_user_i;
                    end
                end
            end
            assign m_user_o = main_user_q;
        end else begin : g_no_user
            logic unused_user;
            assign unused_user = ^s_user_i;
            assign m_user_o    = '0;
        end
    endgenerate

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin merge of N_PORTS AXI-Stream
// sources onto one sink. A grant is held from the first beat through tlast,
// so packets never interleave. Output goes through axis_reg_slice.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : axis_rr_arbiter_if.slave (s_axis_* sources, m_axis_* sink)
//   busy     : grant currently held (registered)
// Optional: define AXIS_RR_ARB_TID_EN to add m_axis_tid (granted index per beat).
//
// state | meaning
// IDLE  | no grant; pick next requester after last_grant, no tready
// GRANT | granted port feeds the slice until its tlast beat is accepted
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int AXIS_DW = 64,
    parameter int AXIS_KW = ((AXIS_DW-1)>>3)+1,
    parameter int N_PORTS = 4,
    parameter int PORT_W  = $clog2(N_PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    axis_rr_arbiter_if.slave bus,
    output logic             busy
);
`ifdef AXIS_RR_ARB_TID_EN
    localparam bit TID_EN = 1'b1;
    localparam int TID_W  = PORT_W;
`else
    localparam bit TID_EN = 1'b0;
    localparam int TID_W  = 1;
`endif

    arb_state_t              state_q, state_d;
    logic [PORT_W-1:0]       grant_q, grant_d;
    logic [PORT_W-1:0]       last_grant_q, last_grant_d;
    logic [RR_MAX_PORTS-1:0] req_pad;

    logic                    slice_in_valid, slice_in_ready;
    logic [AXIS_DW-1:0]      in_data_g;
    logic [AXIS_KW-1:0]      in_keep_g;
    logic                    in_last_g;
    logic [TID_W-1:0]        slice_tid_in, slice_tid_out;

    assign req_pad = RR_MAX_PORTS'(bus.s_axis_tvalid);

    assign in_data_g      = bus.s_axis_tdata[grant_q*AXIS_DW +: AXIS_DW];
    assign in_keep_g      = bus.s_axis_tkeep[grant_q*AXIS_KW +: AXIS_KW];
    assign in_last_g      = bus.s_axis_tlast[grant_q];
    assign slice_in_valid = (state_q == GRANT) && bus.s_axis_tvalid[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|bus.s_axis_tvalid) begin
                    grant_d      = PORT_W'(rr_next_index(req_pad, RR_IDX_W'(last_grant_q), N_PORTS));
                    last_grant_d = grant_d;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (slice_in_valid && slice_in_ready && in_last_g) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = '0;
        if (state_q == GRANT) begin
            bus.s_axis_tready[grant_q] = slice_in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(N_PORTS-1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy = (state_q == GRANT);

`ifdef AXIS_RR_ARB_TID_EN
    assign slice_tid_in   = grant_q;
    assign bus.m_axis_tid = slice_tid_out;
`else
    logic unused_tid;
    assign slice_tid_in = '0;
    assign unused_tid   = ^slice_tid_out;
`endif

    axis_reg_slice #(
        .DW      (AXIS_DW),
        .KW      (AXIS_KW),
        .USER_W  (TID_W),
        .USER_EN (TID_EN)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (slice_in_valid),
        .s_ready_o (slice_in_ready),
        .s_data_i  (in_data_g),
        .s_keep_i  (in_keep_g),
        .s_last_i  (in_last_g),
        .s_user_i  (slice_tid_in),
        .m_valid_o (bus.m_axis_tvalid),
        .m_ready_i (bus.m_axis_tready),
        .m_data_o  (bus.m_axis_tdata),
        .m_keep_o  (bus.m_axis_tkeep),
        .m_last_o  (bus.m_axis_tlast),
        .m_user_o  (slice_tid_out)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
`timescale 1ns/1ps
module tb_axis_rr_arbiter;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.N_PORTS(NP), .AXIS_DW(DW), .AXIS_KW(KW)) bus ();

    axis_rr_arbiter #(.AXIS_DW(DW), .AXIS_KW(KW), .N_PORTS(NP), .PORT_W(PW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; int gap; } beat_t;
    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; int port; } obeat_t;
    typedef struct { int port; int beat; logic [7:0] keep; logic last; int cyc; } logent_t;

    beat_t   src_q [NP][$];
    obeat_t  mq[$];
    logent_t out_log[$];
    logent_t in_log[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [NP-1:0] fire_q = '0;
    logic flush = 1'b0;
    logic tready_toggle = 1'b0;

    // spec-level model state
    logic m_busy = 1'b0;
    int   m_g    = 0;
    int   m_last = NP-1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- source / sink driver ----------------
    initial begin
        beat_t b;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (flush) begin
                    src_q[i].delete();
                    bus.s_axis_tvalid[i] = 1'b0;
                end else begin
                    if (bus.s_axis_tvalid[i] && fire_q[i]) begin
                        src_q[i].delete(0);
                        bus.s_axis_tvalid[i] = 1'b0;
                    end
                    if (!bus.s_axis_tvalid[i] && src_q[i].size() > 0) begin
                        b = src_q[i][0];
                        if (b.gap > 0) begin
                            b.gap = b.gap - 1;
                            src_q[i][0] = b;
                        end else begin
                            bus.s_axis_tvalid[i]          = 1'b1;
                            bus.s_axis_tdata[i*DW +: DW]  = b.data;
                            bus.s_axis_tkeep[i*KW +: KW]  = b.keep;
                            bus.s_axis_tlast[i]           = b.last;
                        end
                    end
                end
            end
            flush = 1'b0;
            if (tready_toggle) bus.m_axis_tready = ~bus.m_axis_tready;
            else               bus.m_axis_tready = 1'b1;
        end
    end

    // ---------------- model + per-cycle compare ----------------
    initial begin
        logic [NP-1:0] exp_ready;
        logic          mfire;
        obeat_t        ob;
        logent_t       le;
        int            p;
        forever begin
            @(negedge clk);
            cyc++;
            exp_ready = '0;
            if (m_busy && mq.size() < 2) exp_ready[m_g] = 1'b1;
            chk("busy", 64'(busy), 64'(m_busy));
            chk("s_tready", 64'(bus.s_axis_tready), 64'(exp_ready));
            chk("m_tvalid", 64'(bus.m_axis_tvalid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_tdata", bus.m_axis_tdata, mq[0].data);
                chk("m_tkeep", 64'(bus.m_axis_tkeep), 64'(mq[0].keep));
                chk("m_tlast", 64'(bus.m_axis_tlast), 64'(mq[0].last));
`ifdef AXIS_RR_ARB_TID_EN
                chk("m_tid", 64'(bus.m_axis_tid), 64'(mq[0].port));
`endif
            end
            for (int i = 0; i < NP; i++) begin
                fire_q[i] = bus.s_axis_tvalid[i] && bus.s_axis_tready[i];
                if (fire_q[i]) begin
                    le.port = i; le.beat = 0; le.keep = bus.s_axis_tkeep[i*KW +: KW];
                    le.last = bus.s_axis_tlast[i]; le.cyc = cyc;
                    in_log.push_back(le);
                end
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                le.port = int'(bus.m_axis_tdata[63:56]); le.beat = int'(bus.m_axis_tdata[47:40]);
                le.keep = bus.m_axis_tkeep; le.last = bus.m_axis_tlast; le.cyc = cyc;
                out_log.push_back(le);
            end
            // advance model one clock
            if (rst) begin
                m_busy = 1'b0; m_g = 0; m_last = NP-1; mq.delete();
            end else begin
                mfire = exp_ready[m_g] && bus.s_axis_tvalid[m_g];
                if (mq.size() > 0 && bus.m_axis_tready) mq.delete(0);
                if (m_busy) begin
                    if (mfire) begin
                        ob.data = bus.s_axis_tdata[m_g*DW +: DW];
                        ob.keep = bus.s_axis_tkeep[m_g*KW +: KW];
                        ob.last = bus.s_axis_tlast[m_g];
                        ob.port = m_g;
                        mq.push_back(ob);
                        if (ob.last) m_busy = 1'b0;
                    end
                end else if (|bus.s_axis_tvalid) begin
                    for (int k = 1; k <= NP; k++) begin
                        p = (m_last + k) % NP;
                        if (!m_busy && bus.s_axis_tvalid[p]) begin
                            m_g = p; m_last = p; m_busy = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic add_pkt(input int port, input int pkt, input int n, input logic [7:0] last_keep,
                           input int first_gap, input int gap_at, input int gap_len);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = {8'(port), 8'(pkt), 8'(k), 40'h5A_C0FF_EE00 ^ 40'(k * 7)};
            b.keep = (k == n-1) ? last_keep : 8'hFF;
            b.last = (k == n-1);
            b.gap  = (k == 0) ? first_gap : ((k == gap_at) ? gap_len : 0);
            src_q[port].push_back(b);
        end
    endtask

    function automatic logic all_idle();
        logic r;
        r = !m_busy && (mq.size() == 0) && (bus.s_axis_tvalid == '0);
        for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!all_idle() && n < budget);
        checks++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s timeout after %0d cycles, expected drain", name, n);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic start_test();
        out_log.delete();
        in_log.delete();
    endtask

    task automatic chk_seq(input string name, input int n, input logic [63:0] seq);
        logic [63:0] act;
        act = '0;
        for (int k = 0; k < out_log.size() && k < 16; k++) act[k*4 +: 4] = 4'(out_log[k].port);
        chk({name, "_count"}, 64'(out_log.size()), 64'(n));
        chk({name, "_ports"}, act, seq);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_m_tdata",  bus.m_axis_tdata, 64'd0);
        chk("rst_m_tkeep",  64'(bus.m_axis_tkeep), 64'd0);
        chk("rst_m_tlast",  64'(bus.m_axis_tlast), 64'd0);
        chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);
`ifdef AXIS_RR_ARB_TID_EN
        chk("rst_m_tid",    64'(bus.m_axis_tid), 64'd0);
`endif
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [63:0] v;
        int bad, edges;
        repeat (3) @(posedge clk);
        #2;
        do_reset();

        // T1: single 3-beat packet on port 0
        start_test();
        add_pkt(0, 1, 3, 8'hFF, 0, -1, 0);
        wait_done("t1", 50);
        chk_seq("t1", 3, 64'h000);
        v = '0;
        for (int k = 0; k < out_log.size() && k < 64; k++) v[k] = out_log[k].last;
        chk("t1_last_flags", v, 64'b100);
        if (in_log.size() > 0 && out_log.size() > 0)
            chk("t1_latency", 64'(out_log[0].cyc - in_log[0].cyc), 64'd1);
        else
            chk("t1_latency_present", 64'(out_log.size() > 0 && in_log.size() > 0), 64'd1);

        // T2: all ports requesting, 2-beat packets; port 0 has two
        do_reset();
        start_test();
        add_pkt(0, 1, 2, 8'hFF, 0, -1, 0);
        add_pkt(0, 2, 2, 8'hFF, 0, -1, 0);
        add_pkt(1, 1, 2, 8'hFF, 0, -1, 0);
        add_pkt(2, 1, 2, 8'hFF, 0, -1, 0);
        add_pkt(3, 1, 2, 8'hFF, 0, -1, 0);
        wait_done("t2", 100);
        chk_seq("t2", 10, 64'h00_3322_1100);
        bad = 0; edges = 0;
        for (int k = 1; k < in_log.size(); k++) begin
            if (in_log[k-1].last) begin
                edges++;
                if (in_log[k].cyc - in_log[k-1].cyc != 2) bad++;
            end
        end
        chk("t2_src_bubble_bad", 64'(bad), 64'd0);
        chk("t2_pkt_edges", 64'(edges), 64'd4);

        // T3a: port 2 packet, port 1 requests during beat 2, port 3 idle
        start_test();
        add_pkt(2, 1, 4, 8'hFF, 0, -1, 0);
        add_pkt(1, 1, 2, 8'hFF, 2, -1, 0);
        wait_done("t3a", 100);
        chk_seq("t3a", 6, 64'h11_2222);

        // T3b: same, port 3 also requests before port 2 finishes
        start_test();
        add_pkt(2, 2, 4, 8'hFF, 0, -1, 0);
        add_pkt(1, 2, 2, 8'hFF, 2, -1, 0);
        add_pkt(3, 2, 2, 8'hFF, 3, -1, 0);
        wait_done("t3b", 100);
        chk_seq("t3b", 8, 64'h1133_2222);

        // T4: 8-beat packet under 1010 backpressure, final tkeep 0F
        start_test();
        tready_toggle = 1'b1;
        add_pkt(3, 3, 8, 8'h0F, 0, -1, 0);
        wait_done("t4", 200);
        tready_toggle = 1'b0;
        chk_seq("t4", 8, 64'h3333_3333);
        bad = 0;
        for (int k = 0; k < out_log.size(); k++) if (out_log[k].beat != k) bad++;
        chk("t4_beat_order", 64'(bad), 64'd0);
        v = '0;
        for (int k = 0; k < out_log.size() && k < 64; k++) v[k] = out_log[k].last;
        chk("t4_last_flags", v, 64'h80);
        if (out_log.size() == 8) chk("t4_last_keep", 64'(out_log[7].keep), 64'h0F);
        else                     chk("t4_last_keep_present", 64'(out_log.size()), 64'd8);

        // T5: 2-cycle tvalid gap mid-packet, port 1 waiting
        start_test();
        add_pkt(0, 4, 4, 8'hFF, 0, 2, 2);
        add_pkt(1, 4, 2, 8'hFF, 1, -1, 0);
        wait_done("t5", 100);
        chk_seq("t5", 6, 64'h11_0000);

        // T6: reset mid-packet, then ports 3 and 0 request together
        start_test();
        add_pkt(2, 5, 6, 8'hFF, 0, -1, 0);
        repeat (4) @(posedge clk);
        #2;
        do_reset();
        start_test();
        add_pkt(3, 6, 2, 8'hFF, 0, -1, 0);
        add_pkt(0, 6, 2, 8'hFF, 0, -1, 0);
        wait_done("t6", 100);
        chk_seq("t6", 4, 64'h3300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle=%0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
